alu_mult_sequencer: RTL and testbench
=====================================

// Module: alu_mult_sequencer
// PURPOSE
//  Multi-cycle unsigned multiply controller that borrows the shared 32-bit ALU.
//  Runs shift-and-add: each RUN cycle drives the ALU with the add code (3'b010),
//  A = running accumulator, B = shifted multiplicand or zero.
//  Sits beside the single-cycle datapath and owns the ALU operand/control muxes while busy.
//  Result is the low WIDTH bits of the product (mod 2^WIDTH).
// PARAMETERS
//  WIDTH  32  operand, accumulator and ALU width
//  CNT_W  6   step-counter width; must satisfy 2^CNT_W > WIDTH
// PORTS
//  clk           in   1      single clock, rising edge
//  reset         in   1      synchronous, active-high
//  start         in   1      request; sampled only in IDLE
//  multiplicand  in   WIDTH  operand A; latched on accepted start
//  multiplier    in   WIDTH  operand B; latched on accepted start
//  alu_out       in   WIDTH  result from shared ALU (combinational)
//  alu_control   out  3      ALU op: 3'b010 in RUN, 3'b000 otherwise
//  alu_a         out  WIDTH  accumulator in RUN, 0 otherwise
//  alu_b         out  WIDTH  mcand_sh if mplier_sh[0] else 0 in RUN; 0 otherwise
//  busy          out  1      high in RUN and DONE
//  done          out  1      one-cycle pulse, product valid
//  product       out  WIDTH  result; held from DONE until next accepted start
// BEHAVIOUR
//  - Reset: state=IDLE; busy=0, done=0, product=0, acc=0, counter=0;
//    alu_control=3'b000, alu_a=0, alu_b=0. Reset wins over every other event.
//  - States: IDLE -> RUN -> DONE -> IDLE.
//  - IDLE: start=1 at edge k latches mcand_sh=multiplicand, mplier_sh=multiplier;
//    sets acc=0, count=0; state=RUN from cycle k+1. start=0 keeps IDLE.
//  - RUN step, on each edge: acc<=alu_out; mcand_sh<<=1 (zero fill);
//    mplier_sh>>=1 (zero fill); count<=count+1.
//  - Exit RUN after a step when count==WIDTH-1 or the post-shift mplier_sh==0
//    (early termination). product<=alu_out on that edge.
//  - RUN step count N = index of highest set bit of multiplier + 1; N=1 when
//    multiplier==0; N never exceeds WIDTH.
//  - DONE: done=1 for exactly one cycle (cycle k+1+N), then IDLE.
//    A new start is first accepted in the following IDLE cycle.
//  - start while busy is ignored; it is neither queued nor an error.
//  - Operand input changes after acceptance have no effect.
//  - Overflow: bits >= WIDTH are discarded; the design raises no flag.
//  - ALU ports are registered-state driven (no input->output comb path).
//    alu_out is sampled only in RUN.
//  - Reset asserted mid-RUN or in DONE: next cycle IDLE, no done pulse, product=0.
// TESTING
//  1) reset 2 cycles -> busy=0, done=0, product=0, alu_control=000, alu_a=alu_b=0.
//  2) start, 6 x 7 -> 3 RUN cycles with alu_control=010; done at k+4; product=42.
//  3) start, 5 x 0 -> 1 RUN cycle; done at k+2; product=0.
//  4) start, 32'hFFFF_FFFF x 32'h8000_0001 -> 32 RUN cycles; done at k+33;
//     product=32'h7FFF_FFFF.
//  5) start pulsed again during RUN with 3 x 3 -> ignored; the first product stands;
//     the next start after done computes 9.
//  6) reset asserted in 2nd RUN cycle of 1234 x 5678 -> IDLE next cycle; no done;
//     product=0; a fresh start then yields 7006652.

Source files
------------

// File: rtl/alu_mult_sequencer.sv
// rtl/alu_mult_sequencer.sv - shift-and-add unsigned multiply sequencer on a shared ALU
//
// Computes the low WIDTH bits of multiplicand * multiplier by borrowing the
// shared single-cycle ALU. While the ALU is borrowed, it is always issued an add.
//
// Ports
//   clk_i            clock, rising edge
//   reset_i          synchronous, active-high reset
//   start_i          multiply request, only accepted when idle
//   multiplicand_i   operand A, latched on an accepted start
//   multiplier_i     operand B, latched on an accepted start
//   alu_out_i        combinational result from the shared ALU
//   alu_control_o    ALU opcode: add while running, 3'b000 otherwise
//   alu_a_o          ALU operand A: running accumulator while running, else 0
//   alu_b_o          ALU operand B: shifted multiplicand or 0 while running, else 0
//   busy_o           high while running and in the done cycle
//   done_o           one-cycle pulse when product_o becomes valid
//   product_o        result, held until overwritten by the next completion
module alu_mult_sequencer #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 6
) (
  input  logic             clk_i,
  input  logic             reset_i,
  input  logic             start_i,
  input  logic [WIDTH-1:0] multiplicand_i,
  input  logic [WIDTH-1:0] multiplier_i,
  input  logic [WIDTH-1:0] alu_out_i,
  output logic [2:0]       alu_control_o,
  output logic [WIDTH-1:0] alu_a_o,
  output logic [WIDTH-1:0] alu_b_o,
  output logic             busy_o,
  output logic             done_o,
  output logic [WIDTH-1:0] product_o
);

  localparam logic [2:0] ALU_ADD = 3'b010;
  localparam logic [2:0] ALU_NOP = 3'b000;

  typedef enum logic [1:0] {
    S_IDLE = 2'b00,
    S_RUN  = 2'b01,
    S_DONE = 2'b10
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] mcand_q;
  logic [WIDTH-1:0] mplier_q;
  logic [WIDTH-1:0] acc_q;
  logic [WIDTH-1:0] product_q;
  logic [CNT_W-1:0] count_q;
  logic             last_step;

  // Stop after this step if the counter has reached the final bit position, or
  // if no set multiplier bits remain once the current bit is shifted out.
  assign last_step = (count_q == CNT_W'(WIDTH - 1)) || ((mplier_q >> 1) == '0);

  // State register
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (start_i) state_d = S_RUN;
      S_RUN:   if (last_step) state_d = S_DONE;
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Datapath registers; alu_out_i is only consumed during RUN.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      mcand_q   <= '0;
      mplier_q  <= '0;
      acc_q     <= '0;
      count_q   <= '0;
      product_q <= '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (start_i) begin
            mcand_q  <= multiplicand_i;
            mplier_q <= multiplier_i;
            acc_q    <= '0;
            count_q  <= '0;
          end
        end
        S_RUN: begin
          acc_q    <= alu_out_i;
          mcand_q  <= mcand_q << 1;
          mplier_q <= mplier_q >> 1;
          count_q  <= count_q + 1'b1;
          if (last_step) begin
            product_q <= alu_out_i;
          end
        end
        default: ;
      endcase
    end
  end

  // Output logic: driven from registered state only, no start/operand paths.
  always_comb begin
    alu_control_o = ALU_NOP;
    alu_a_o       = '0;
    alu_b_o       = '0;
    busy_o        = 1'b0;
    done_o        = 1'b0;
    case (state_q)
      S_RUN: begin
        alu_control_o = ALU_ADD;
        alu_a_o       = acc_q;
        alu_b_o       = mplier_q[0] ? mcand_q : '0;
        busy_o        = 1'b1;
      end
      S_DONE: begin
        busy_o = 1'b1;
        done_o = 1'b1;
      end
      default: ;
    endcase
  end

  assign product_o = product_q;

endmodule

// File: tb/tb_alu_mult_sequencer.sv
// tb/tb_alu_mult_sequencer.sv - self-checking bench for alu_mult_sequencer
module tb_alu_mult_sequencer;

  logic        clk;
  logic        reset;
  logic        start;
  logic [31:0] multiplicand;
  logic [31:0] multiplier;
  logic [31:0] alu_out;
  logic [2:0]  alu_control;
  logic [31:0] alu_a;
  logic [31:0] alu_b;
  logic        busy;
  logic        done;
  logic [31:0] product;

  int checks = 0;
  int errors = 0;
  logic [31:0] sb_q[$];

  alu_mult_sequencer #(.WIDTH(32), .CNT_W(6)) dut (
    .clk_i          (clk),
    .reset_i        (reset),
    .start_i        (start),
    .multiplicand_i (multiplicand),
    .multiplier_i   (multiplier),
    .alu_out_i      (alu_out),
    .alu_control_o  (alu_control),
    .alu_a_o        (alu_a),
    .alu_b_o        (alu_b),
    .busy_o         (busy),
    .done_o         (done),
    .product_o      (product)
  );

  // Shared ALU model: add for 3'b010, AND for anything else.
  always_comb begin
    if (alu_control == 3'b010) alu_out = alu_a + alu_b;
    else                       alu_out = alu_a & alu_b;
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic int exp_steps(input logic [31:0] m);
    int n = 1;
    for (int i = 0; i < 32; i++) if (m[i]) n = i + 1;
    return n;
  endfunction

  // Issue one multiply, track it through the scoreboard and check latency,
  // RUN-cycle count, ALU opcode and the product. When inject is set, a second
  // start with different operands is pulsed mid-RUN and must be ignored.
  task automatic do_mult(input string tag, input logic [31:0] a, input logic [31:0] b,
                         input bit inject);
    int n_exp;
    int cyc;
    int run_cnt;
    logic [31:0] exp_p;
    n_exp = exp_steps(b);
    @(negedge clk);
    multiplicand = a;
    multiplier   = b;
    start        = 1'b1;
    @(posedge clk);
    sb_q.push_back(a * b);
    #1 start = 1'b0;
    cyc     = 0;
    run_cnt = 0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      cyc++;
      if (inject && cyc == 2) begin
        start = 1'b1; multiplicand = 32'd3; multiplier = 32'd3;
      end
      if (inject && cyc == 3) start = 1'b0;
      if (done) break;
      if (busy && alu_control == 3'b010) run_cnt++;
    end
    start = 1'b0;
    chk({tag, " done_latency"}, cyc, n_exp + 1);
    chk({tag, " run_cycles"}, run_cnt, n_exp);
    if (sb_q.size() == 0) begin
      chk({tag, " scoreboard_nonempty"}, 32'd0, 32'd1);
      exp_p = 'x;
    end else begin
      exp_p = sb_q.pop_front();
    end
    chk({tag, " product"}, product, exp_p);
    @(negedge clk);
    chk({tag, " done_pulse_one_cycle"}, {31'd0, done}, 32'd0);
    chk({tag, " idle_after_done"}, {31'd0, busy}, 32'd0);
    chk({tag, " product_held"}, product, exp_p);
  endtask

  initial begin
    reset = 1'b1;
    start = 1'b0;
    multiplicand = '0;
    multiplier   = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("reset busy", {31'd0, busy}, 32'd0);
    chk("reset done", {31'd0, done}, 32'd0);
    chk("reset product", product, 32'd0);
    chk("reset alu_control", {29'd0, alu_control}, 32'd0);
    chk("reset alu_a", alu_a, 32'd0);
    chk("reset alu_b", alu_b, 32'd0);
    reset = 1'b0;
    @(negedge clk);

    do_mult("6x7", 32'd6, 32'd7, 1'b0);
    do_mult("5x0", 32'd5, 32'd0, 1'b0);
    do_mult("max", 32'hFFFF_FFFF, 32'h8000_0001, 1'b0);
    do_mult("ignored_start", 32'd100, 32'd255, 1'b1);
    do_mult("3x3", 32'd3, 32'd3, 1'b0);

    // Reset during the 2nd RUN cycle aborts the multiply.
    @(negedge clk);
    multiplicand = 32'd1234;
    multiplier   = 32'd5678;
    start        = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk("abort in_run", {29'd0, alu_control}, 32'd2);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    chk("abort busy", {31'd0, busy}, 32'd0);
    chk("abort done", {31'd0, done}, 32'd0);
    chk("abort product", product, 32'd0);
    chk("abort alu_control", {29'd0, alu_control}, 32'd0);
    begin
      int seen = 0;
      for (int i = 0; i < 20; i++) begin
        @(negedge clk);
        if (done) seen++;
      end
      chk("abort no_done", seen, 0);
    end

    do_mult("1234x5678", 32'd1234, 32'd5678, 1'b0);
    chk("scoreboard drained", sb_q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
